// File: rtl/snake_engine.sv
// Snake game move engine: holds the body as head-first slot arrays and executes one move per step.
// Latency: a move commits 2 + scan-count cycles after step, where the scan covers length-1 or length slots.
// Backpressure: busy is high while a move is in flight; step is dropped while busy or after game over.
//
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   step                  - one-cycle move request (game tick)
//   dir_valid, dir[1:0]   - heading request: 00 up, 01 right, 10 down, 11 left
//   grow                  - one-cycle food-eaten pulse, applied on the next committed move
//   x_values, y_values    - slot i at [32*i +: 32], slot 0 is the head, all-ones marks an empty slot
//   length                - occupied slot count
//   game_done             - sticky game-over flag
//   busy                  - move in progress
module snake_engine #(
  parameter int MAX_LEN = 100,
  parameter int GRID_W  = 10,
  parameter int GRID_H  = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         step,
  input  logic                         dir_valid,
  input  logic [1:0]                   dir,
  input  logic                         grow,
  output logic [32*MAX_LEN-1:0]        x_values,
  output logic [32*MAX_LEN-1:0]        y_values,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         game_done,
  output logic                         busy
);

  localparam int LW = $clog2(MAX_LEN + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] RIGHT = 2'd1;
  localparam logic [1:0] DOWN  = 2'd2;
  localparam logic [1:0] LEFT  = 2'd3;

  localparam logic [31:0] GW    = GRID_W;
  localparam logic [31:0] GH    = GRID_H;
  localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

  logic [31:0]   xs [MAX_LEN];
  logic [31:0]   ys [MAX_LEN];
  logic [1:0]    state;
  logic [1:0]    heading;
  logic [1:0]    pending_dir;
  logic          grow_pending;
  logic [31:0]   next_x;
  logic [31:0]   next_y;
  logic [LW-1:0] idx;

  logic          dir_ok;
  logic [1:0]    move_dir;
  logic [31:0]   cand_x;
  logic [31:0]   cand_y;
  logic          out_of_grid;
  logic [LW-1:0] scan_last;
  logic          hit;
  logic [LW-1:0] new_len;

  // Headings are encoded so that the reverse direction differs only in bit 1.
  assign dir_ok   = dir_valid && (dir != (heading ^ 2'b10));
  // A direction presented together with step steers this very move.
  assign move_dir = dir_ok ? dir : pending_dir;

  always_comb begin
    cand_x = xs[0];
    cand_y = ys[0];
    case (move_dir)
      UP:      cand_y = ys[0] - 32'd1;
      RIGHT:   cand_x = xs[0] + 32'd1;
      DOWN:    cand_y = ys[0] + 32'd1;
      LEFT:    cand_x = xs[0] - 32'd1;
      default: cand_x = xs[0];
    endcase
  end

  // Stepping off column/row 0 wraps to all-ones, so one unsigned compare catches both edges.
  assign out_of_grid = (cand_x >= GW) || (cand_y >= GH);

  // Without growth the tail slot vacates during the move, so it is not an obstacle.
  assign scan_last = grow_pending ? (length - LW'(1)) : (length - LW'(2));
  assign hit       = (xs[idx] == next_x) && (ys[idx] == next_y);
  assign new_len   = (grow_pending && (length < LW'(MAX_LEN))) ? (length + LW'(1)) : length;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      heading      <= RIGHT;
      pending_dir  <= RIGHT;
      grow_pending <= 1'b0;
      next_x       <= '0;
      next_y       <= '0;
      idx          <= '0;
      length       <= LW'(3);
      for (int i = 0; i < MAX_LEN; i++) begin
        xs[i] <= EMPTY;
        ys[i] <= EMPTY;
      end
      xs[0] <= 32'd2;  ys[0] <= 32'd5;
      xs[1] <= 32'd1;  ys[1] <= 32'd5;
      xs[2] <= 32'd0;  ys[2] <= 32'd5;
    end else begin
      if (state != DONE && dir_ok) pending_dir <= dir;
      if (state != DONE && grow)   grow_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (step) begin
            heading <= move_dir;
            next_x  <= cand_x;
            next_y  <= cand_y;
            idx     <= '0;
            state   <= out_of_grid ? DONE : CHECK;
          end
        end
        CHECK: begin
          if (hit)                    state <= DONE;
          else if (idx == scan_last)  state <= SHIFT;
          else                        idx   <= idx + LW'(1);
        end
        SHIFT: begin
          xs[0] <= next_x;
          ys[0] <= next_y;
          for (int i = 1; i < MAX_LEN; i++) begin
            if (LW'(i) < new_len) begin
              xs[i] <= xs[i-1];
              ys[i] <= ys[i-1];
            end else begin
              xs[i] <= EMPTY;
              ys[i] <= EMPTY;
            end
          end
          length       <= new_len;
          // The pending growth is consumed here; a pulse landing this cycle carries to the next move.
          grow_pending <= grow;
          state        <= IDLE;
        end
        default: state <= DONE;
      endcase
    end
  end

  assign game_done = (state == DONE);
  assign busy      = (state == CHECK) || (state == SHIFT);

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign x_values[32*g +: 32] = xs[g];
    assign y_values[32*g +: 32] = ys[g];
  end

endmodule

// File: tb/tb_snake_engine.sv
module tb_snake_engine;

  localparam int MAX_LEN = 100;
  localparam int GW = 10;
  localparam int GH = 10;
  localparam logic [1:0] D_UP = 2'd0, D_RIGHT = 2'd1, D_DOWN = 2'd2, D_LEFT = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic step = 1'b0;
  logic dir_valid = 1'b0;
  logic [1:0] dir = 2'd0;
  logic grow = 1'b0;
  logic [32*MAX_LEN-1:0] x_values, y_values;
  logic [6:0] length;
  logic game_done, busy;

  always #5 clk = ~clk;

  snake_engine #(.MAX_LEN(MAX_LEN), .GRID_W(GW), .GRID_H(GH)) dut (
    .clk(clk), .reset(reset), .step(step), .dir_valid(dir_valid), .dir(dir),
    .grow(grow), .x_values(x_values), .y_values(y_values), .length(length),
    .game_done(game_done), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the body as a queue of points, head at index 0.
  typedef struct packed { logic [31:0] x; logic [31:0] y; } pt_t;
  pt_t body[$];
  logic [1:0] m_head, m_pend;
  bit m_grow, m_done;

  typedef struct {
    bit rst; bit dv; logic [1:0] d; bit g;
    int hx; int hy; int len; bit done;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [32*MAX_LEN-1:0] act, input logic [32*MAX_LEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      for (int i = 0; i < MAX_LEN; i++)
        if (act[32*i +: 32] !== exp[32*i +: 32]) begin
          $display("FAIL %s slot %0d: got %0h expected %0h", name, i, act[32*i +: 32], exp[32*i +: 32]);
          break;
        end
    end
  endtask

  task automatic model_reset();
    body.delete();
    body.push_back('{x: 32'd2, y: 32'd5});
    body.push_back('{x: 32'd1, y: 32'd5});
    body.push_back('{x: 32'd0, y: 32'd5});
    m_head = D_RIGHT; m_pend = D_RIGHT; m_grow = 0; m_done = 0;
  endtask

  task automatic check_all(input string tag);
    logic [32*MAX_LEN-1:0] ex, ey;
    ex = '1; ey = '1;
    foreach (body[k]) begin
      ex[32*k +: 32] = body[k].x;
      ey[32*k +: 32] = body[k].y;
    end
    chk_bus({tag, "_x"}, x_values, ex);
    chk_bus({tag, "_y"}, y_values, ey);
    chk({tag, "_len"}, 64'(length), 64'(body.size()));
    chk({tag, "_done"}, 64'(game_done), 64'(m_done));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Model of one move by the game rules; returns how many cycles busy should stay high.
  task automatic model_move(input bit dv, input logic [1:0] d, input bit g, output int exp_cyc);
    pt_t nh;
    int limit, hitk;
    exp_cyc = 0;
    if (m_done) return;
    if (dv && d != (m_head ^ 2'b10)) m_pend = d;
    if (g) m_grow = 1;
    m_head = m_pend;
    nh = body[0];
    case (m_head)
      D_UP:    nh.y = nh.y - 32'd1;
      D_RIGHT: nh.x = nh.x + 32'd1;
      D_DOWN:  nh.y = nh.y + 32'd1;
      default: nh.x = nh.x - 32'd1;
    endcase
    if (nh.x >= GW || nh.y >= GH) begin
      m_done = 1;
      return;
    end
    limit = m_grow ? body.size() - 1 : body.size() - 2;
    hitk = -1;
    for (int k = 0; k <= limit; k++)
      if (hitk < 0 && body[k] == nh) hitk = k;
    if (hitk >= 0) begin
      m_done = 1;
      exp_cyc = hitk + 1;
      return;
    end
    body.push_front(nh);
    if (!m_grow || body.size() > MAX_LEN) void'(body.pop_back());
    m_grow = 0;
    exp_cyc = limit + 2;
  endtask

  task automatic do_move(input bit dv, input logic [1:0] d, input bit g);
    int exp_cyc, cyc;
    step = 1'b1; dir_valid = dv; dir = d; grow = g;
    @(posedge clk); #1;
    step = 1'b0; dir_valid = 1'b0; grow = 1'b0;
    model_move(dv, d, g, exp_cyc);
    cyc = 0;
    while (busy && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("busy_cycles", 64'(cyc), 64'(exp_cyc));
    check_all("move");
  endtask

  initial begin
    tbl[0]  = '{1, 1, D_LEFT,  0, 3, 5, 3, 0};
    tbl[1]  = '{0, 0, D_RIGHT, 1, 4, 5, 4, 0};
    tbl[2]  = '{0, 1, D_DOWN,  0, 4, 6, 4, 0};
    tbl[3]  = '{0, 1, D_LEFT,  1, 3, 6, 5, 0};
    tbl[4]  = '{0, 1, D_UP,    0, 3, 6, 5, 1};
    tbl[5]  = '{0, 0, D_UP,    0, 3, 6, 5, 1};
    tbl[6]  = '{1, 0, D_RIGHT, 1, 3, 5, 4, 0};
    tbl[7]  = '{0, 1, D_DOWN,  0, 3, 6, 4, 0};
    tbl[8]  = '{0, 1, D_LEFT,  0, 2, 6, 4, 0};
    tbl[9]  = '{0, 1, D_UP,    0, 2, 5, 4, 0};
    tbl[10] = '{0, 1, D_DOWN,  0, 2, 4, 4, 0};
    tbl[11] = '{1, 1, D_UP,    0, 2, 4, 3, 0};
    tbl[12] = '{0, 1, D_LEFT,  0, 1, 4, 3, 0};
    tbl[13] = '{0, 0, D_LEFT,  0, 0, 4, 3, 0};
    tbl[14] = '{0, 0, D_LEFT,  0, 0, 4, 3, 1};

    // Reset state
    do_reset();
    check_all("reset");

    // Scripted sequences with hand-derived head/length/done expectations
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) do_reset();
      do_move(tbl[i].dv, tbl[i].d, tbl[i].g);
      chk($sformatf("tbl%0d_hx", i), 64'(x_values[31:0]), 64'(tbl[i].hx));
      chk($sformatf("tbl%0d_hy", i), 64'(y_values[31:0]), 64'(tbl[i].hy));
      chk($sformatf("tbl%0d_len", i), 64'(length), 64'(tbl[i].len));
      chk($sformatf("tbl%0d_done", i), 64'(game_done), 64'(tbl[i].done));
    end

    // Right wall: seven steps reach column 9, the eighth ends the game
    do_reset();
    for (int i = 0; i < 7; i++) do_move(0, D_RIGHT, 0);
    chk("wall_head_x", 64'(x_values[31:0]), 64'd9);
    do_move(0, D_RIGHT, 0);
    chk("wall_done", 64'(game_done), 64'd1);
    chk("wall_frozen_x", 64'(x_values[31:0]), 64'd9);
    do_move(1, D_UP, 1);
    chk("wall_after_len", 64'(length), 64'd3);

    // Step while busy is dropped
    do_reset();
    step = 1'b1; @(posedge clk); #1; step = 1'b0;
    step = 1'b1; @(posedge clk); #1; step = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    chk("busy_step_hx", 64'(x_values[31:0]), 64'd3);
    chk("busy_step_idle", 64'(busy), 64'd0);
    chk("busy_step_len", 64'(length), 64'd3);

    // Reset during CHECK of a growing move
    do_reset();
    step = 1'b1; grow = 1'b1; @(posedge clk); #1; step = 1'b0; grow = 1'b0;
    chk("mid_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    do_move(0, D_RIGHT, 0);

    // Random play against the queue model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_done || $urandom_range(0, 49) == 0) do_reset();
      do_move(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
